aes_encipher_block: RTL and testbench
=====================================

AES_ENCIPHER_BLOCK -- requirements
Module: aes_encipher_block

Interface
REQ-001 The block SHALL have a clock input clk, rising-edge active.
REQ-002 The block SHALL have a reset input reset_n, asynchronous, active-low.
REQ-003 Port list:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- next  in  1  start-encipher request, sampled in IDLE only.
- keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds).
- round  out  4  current round index, used by the key memory to select round_key.
- round_key  in  128  round key for the current round, valid combinationally from round.
- sboxw  out  32  word presented to the shared external S-box.
- new_sboxw  in  32  S-box result for sboxw, combinational.
- block  in  128  plaintext, sampled in INIT.
- new_block  out  128  state register {w0,w1,w2,w3}; holds ciphertext when ready=1 after a run.
- ready  out  1  1 = idle/done, 0 = busy.
- abort  in  1  present only with AES_ENC_ABORT_EN.

Function
REQ-004 FSM states SHALL be IDLE, INIT, SBOX and MAIN.
REQ-005 Transitions SHALL be:
- IDLE: on next=1, ready<=0, round<=0, go to INIT; next=0 stays in IDLE.
- INIT: state<=block^round_key; round<=1; sword counter<=0; go to SBOX.
- SBOX: for 4 cycles, sword counter s=0..3, sboxw=w[s], w[s]<=new_sboxw, s<=s+1; after s=3, go to MAIN.
- MAIN, round<Nr: state<=MixColumns(ShiftRows(state))^round_key; round<=round+1; s<=0; go to SBOX.
- MAIN, round==Nr: state<=ShiftRows(state)^round_key; ready<=1; go to IDLE.
REQ-006 Nr SHALL be 10 for keylen=0 and 14 for keylen=1; keylen is sampled on the IDLE->INIT edge and held internally for the run.
REQ-007 ShiftRows SHALL follow FIPS-197 with column-major byte order: out word i = {w[i][31:24], w[i+1][23:16], w[i+2][15:8], w[i+3][7:0]}, indices mod 4.
REQ-008 MixColumns SHALL use GF(2^8) with polynomial 0x11B and coefficients 2,3,1,1 rotated per row.
REQ-009 Latency SHALL be 5*Nr+1 clock edges from the edge that samples next=1 to the edge that sets ready=1: 51 for AES-128 and 71 for AES-256.
REQ-010 sboxw SHALL be 32'h0 outside SBOX.
REQ-011 next SHALL be ignored while ready=0, with no restart or effect on the state.
REQ-012 new_block SHALL hold its value in IDLE until the next INIT.
REQ-013 A next=1 on the same cycle ready rises SHALL be ignored, because the FSM is still in MAIN; next is accepted from the following cycle.
REQ-014 The round counter SHALL be 4 bits and SHALL never exceed 14.

Reset
REQ-015 While reset_n=0, the block SHALL force: state regs = 0, new_block = 0, sword counter = 0, round = 0, ready = 1, FSM = IDLE.
REQ-016 Reset asserted mid-operation SHALL abandon the run immediately, with no partial ciphertext retained.

Configuration
REQ-017 The macro AES_ENC_ABORT_EN SHALL control the abort feature.
- Defined: abort=1 in INIT, SBOX or MAIN SHALL, on the next edge, clear the state regs to 0, set ready=1 and return to IDLE.
- Defined: abort has priority over the MAIN final update on the same cycle.
- Defined: abort in IDLE SHALL have no effect.
- Not defined: the abort port and its logic SHALL be absent.

Verification
REQ-018 The bench SHALL cover these scenarios, with round_key supplied by a bench key-schedule model indexed by round:
- FIPS-197 C.1, AES-128: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a, ready after exactly 51 edges.
- FIPS-197 C.3, AES-256: key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, ready after 71 edges.
- next pulsed repeatedly while busy -> result and latency identical to the C.1 run.
- reset_n pulsed low at cycle 20 of a C.1 run -> new_block=0, ready=1, round=0; a fresh C.1 run then passes.
- keylen toggled mid-run after start=0 -> still 10 rounds, C.1 result.
- With AES_ENC_ABORT_EN: abort at cycle 30 -> next edge ready=1, new_block=0; a subsequent C.3 run passes.

Source files
------------

// File: rtl/aes_encipher_block.sv
// AES encipher datapath: SubBytes one word per cycle via a shared external S-box, 5 cycles per round.
// Optional abort input is compiled in when AES_ENC_ABORT_EN is defined.
module aes_encipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
`ifdef AES_ENC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    // Handshake: next is taken only while ready=1 (IDLE); ready falls on the accepting
    // edge and rises on the edge that writes the ciphertext into new_block.
    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} fsm_t;

    fsm_t         fsm_q;
    logic [1:0]   sword;
    logic         keylen_q;
    logic [3:0]   num_rounds;
    logic [127:0] sr_block;
    logic [127:0] mc_block;
    logic         abort_hit;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        w0 = s[127:96];
        w1 = s[95:64];
        w2 = s[63:32];
        w3 = s[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

    assign num_rounds = keylen_q ? 4'd14 : 4'd10;
    assign sr_block   = shift_rows(new_block);
    assign mc_block   = {mix_word(sr_block[127:96]), mix_word(sr_block[95:64]),
                         mix_word(sr_block[63:32]),  mix_word(sr_block[31:0])};

    always_comb begin
        abort_hit = 1'b0;
`ifdef AES_ENC_ABORT_EN
        abort_hit = abort && (fsm_q != IDLE);
`endif
    end

    // The shared S-box must see zero whenever this block is not substituting.
    always_comb begin
        sboxw = 32'h0;
        if (fsm_q == SBOX) begin
            case (sword)
                2'd0:    sboxw = new_block[127:96];
                2'd1:    sboxw = new_block[95:64];
                2'd2:    sboxw = new_block[63:32];
                default: sboxw = new_block[31:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q     <= IDLE;
            new_block <= '0;
            sword     <= 2'd0;
            round     <= 4'd0;
            ready     <= 1'b1;
            keylen_q  <= 1'b0;
        end else if (abort_hit) begin
            fsm_q     <= IDLE;
            new_block <= '0;
            sword     <= 2'd0;
            round     <= 4'd0;
            ready     <= 1'b1;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (next) begin
                        ready    <= 1'b0;
                        round    <= 4'd0;
                        keylen_q <= keylen;
                        fsm_q    <= INIT;
                    end
                end
                INIT: begin
                    new_block <= block ^ round_key;
                    round     <= 4'd1;
                    sword     <= 2'd0;
                    fsm_q     <= SBOX;
                end
                SBOX: begin
                    case (sword)
                        2'd0:    new_block[127:96] <= new_sboxw;
                        2'd1:    new_block[95:64]  <= new_sboxw;
                        2'd2:    new_block[63:32]  <= new_sboxw;
                        default: new_block[31:0]   <= new_sboxw;
                    endcase
                    sword <= sword + 2'd1;
                    if (sword == 2'd3) begin
                        fsm_q <= MAIN;
                    end
                end
                MAIN: begin
                    if (round < num_rounds) begin
                        new_block <= mc_block ^ round_key;
                        round     <= round + 4'd1;
                        sword     <= 2'd0;
                        fsm_q     <= SBOX;
                    end else begin
                        new_block <= sr_block ^ round_key;
                        ready     <= 1'b1;
                        fsm_q     <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench for aes_encipher_block: byte-level AES model, key-schedule model and S-box model.
// Define AES_ENC_ABORT_EN to also exercise the abort input.
module tb_aes_encipher_block;

    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         next = 1'b0;
    logic         keylen = 1'b0;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block = '0;
    logic [127:0] new_block;
    logic         ready;
`ifdef AES_ENC_ABORT_EN
    logic         abort = 1'b0;
`endif

    logic [127:0] rk [0:14];
    logic [127:0] exp_q [$];
    logic [127:0] exp_hold = '0;
    bit           run_active = 1'b0;
    int           run_k = 0;
    int           run_nr = 10;
    bit           cmp_en = 1'b0;
    int           checks = 0;
    int           failures = 0;
    int           lat;
    logic [255:0] rnd_key;
    logic [127:0] rnd_pt;
    bit           rnd_kl;
    int           rnd_nr;

    always #5 clk = ~clk;

    aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
`ifdef AES_ENC_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, base, e;
        r = 8'h01;
        base = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign round_key = rk[round];
    assign new_sboxw = sub_word(sboxw);

    task automatic expand_key(input logic [255:0] key, input bit kl);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, total;
        nk = kl ? 8 : 4;
        total = kl ? 60 : 44;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Reference cipher on a 16-byte column-major array using the current rk table.
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input int nr);
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic int exp_round(input int k, input int nr);
        int r;
        if (k == 0) return 0;
        r = (k - 1) / 5 + 1;
        return (r > nr) ? nr : r;
    endfunction

    // Timeline model: busy for 5*Nr+1 edges after the accepting edge, then idle holding the result.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_active <= 1'b0;
            run_k      <= 0;
            exp_hold   <= '0;
            exp_q.delete();
        end
`ifdef AES_ENC_ABORT_EN
        else if (run_active && abort) begin
            run_active <= 1'b0;
            exp_hold   <= '0;
            exp_q.delete();
        end
`endif
        else if (run_active) begin
            if (run_k + 1 == 5 * run_nr + 1) begin
                run_active <= 1'b0;
                exp_hold   <= exp_q.pop_front();
            end
            run_k <= run_k + 1;
        end else if (next) begin
            run_active <= 1'b1;
            run_k      <= 0;
            run_nr     <= keylen ? 14 : 10;
            exp_q.push_back(aes_model(block, keylen ? 14 : 10));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (run_active) begin
                check("busy_ready", ready, 0);
                check("busy_round", round, exp_round(run_k, run_nr));
                if (!(run_k >= 1 && (run_k - 1) % 5 < 4)) check("sboxw_zero", sboxw, 0);
            end else begin
                check("idle_ready", ready, 1);
                check("idle_block", new_block, exp_hold);
                check("idle_sboxw", sboxw, 0);
            end
        end
    end

    task automatic kick(input logic [127:0] pt, input logic [255:0] key, input bit kl);
        @(negedge clk);
        expand_key(key, kl);
        block = pt;
        keylen = kl;
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    // mode 1: random next while busy (forced high on the completing edge); mode 2: toggle keylen.
    task automatic wait_ready(input int mode, input int nr, output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (ready) break;
            if (mode == 1) next = (n == 5 * nr) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mode == 2) keylen = ~keylen;
        end
        next = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        expand_key(K128, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_block", new_block, 0);
        check("rst_round", round, 0);
        check("rst_sboxw", sboxw, 0);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        check("model_c1", aes_model(PT, 10), C1);
        expand_key(K256, 1'b1);
        check("model_c3", aes_model(PT, 14), C3);

        kick(PT, K128, 1'b0);
        wait_ready(0, 10, lat);
        check("c1_latency", lat, 51);
        check("c1_result", new_block, C1);

        kick(PT, K256, 1'b1);
        wait_ready(0, 14, lat);
        check("c3_latency", lat, 71);
        check("c3_result", new_block, C3);

        kick(PT, K128, 1'b0);
        wait_ready(1, 10, lat);
        check("busy_next_latency", lat, 51);
        check("busy_next_result", new_block, C1);
        repeat (2) @(negedge clk);
        check("after_ignored_next", ready, 1);

        kick(PT, K128, 1'b0);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_block", new_block, 0);
        check("midrst_ready", ready, 1);
        check("midrst_round", round, 0);
        @(negedge clk);
        reset_n = 1'b1;
        kick(PT, K128, 1'b0);
        wait_ready(0, 10, lat);
        check("post_rst_latency", lat, 51);
        check("post_rst_result", new_block, C1);

        kick(PT, K128, 1'b0);
        wait_ready(2, 10, lat);
        keylen = 1'b0;
        check("keylen_toggle_latency", lat, 51);
        check("keylen_toggle_result", new_block, C1);

`ifdef AES_ENC_ABORT_EN
        kick(PT, K128, 1'b0);
        repeat (30) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_block", new_block, 0);
        kick(PT, K256, 1'b1);
        wait_ready(0, 14, lat);
        check("post_abort_latency", lat, 71);
        check("post_abort_result", new_block, C3);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("idle_abort_block", new_block, C3);
`endif

        for (int n = 0; n < 6; n++) begin
            rnd_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
            rnd_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rnd_kl  = 1'($urandom_range(0, 1));
            rnd_nr  = rnd_kl ? 14 : 10;
            kick(rnd_pt, rnd_key, rnd_kl);
            wait_ready(int'($urandom_range(0, 1)), rnd_nr, lat);
            keylen = 1'b0;
            check("rand_latency", lat, 5 * rnd_nr + 1);
            check("rand_result", new_block, aes_model(rnd_pt, rnd_nr));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
